// File: rtl/mem_wb_writeback.sv
// Memory/writeback pipeline stage: registers EM results, aligns load data and drives the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_writeback #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_EM,
    input  logic            reg_wr_EM,
    input  logic [4:0]      rd_EM,
    input  logic [1:0]      wb_sel_EM,
    input  logic [2:0]      funct3_EM,
    input  logic [XLEN-1:0] alu_out_EM,
    input  logic [XLEN-1:0] pc_EM,
    input  logic [XLEN-1:0] csr_rdata_EM,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            valid_MW,
    output logic            reg_wrMW,
    output logic [4:0]      waddr_MW,
    output logic [XLEN-1:0] wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_count
`endif
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    // The alignment logic below is written for a 32-bit datapath only.
    if (XLEN != 32 || CNT_W < 1) begin : g_bad_cfg
        $error("mem_wb_writeback: XLEN must be 32 and CNT_W at least 1");
    end

    logic [1:0]      off;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;

    assign off = alu_out_EM[1:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        load_byte = dmem_rdata[7:0];
        load_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        wb_data   = alu_out_EM;

        case (off)
            2'd1:    load_byte = dmem_rdata[15:8];
            2'd2:    load_byte = dmem_rdata[23:16];
            2'd3:    load_byte = dmem_rdata[31:24];
            default: load_byte = dmem_rdata[7:0];
        endcase

        // Undefined size codes fall through to a full-word load.
        case (funct3_EM)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = dmem_rdata;
        endcase

        case (wb_sel_e'(wb_sel_EM))
            WB_ALU:  wb_data = alu_out_EM;
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = pc_EM + XLEN'(4);
            WB_CSR:  wb_data = csr_rdata_EM;
            default: wb_data = alu_out_EM;
        endcase
    end

    // Priority rst > flush > stall > capture; a held write simply repeats.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_MW <= 1'b0;
            reg_wrMW <= 1'b0;
            waddr_MW <= '0;
            wdata    <= '0;
        end else if (!stall) begin
            valid_MW <= valid_EM;
            reg_wrMW <= valid_EM & reg_wr_EM & (rd_EM != 5'd0);
            waddr_MW <= rd_EM;
            wdata    <= wb_data;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= '0;
        end else if (!flush && !stall && valid_EM) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: a reference model pushes expected MW state into a queue
// as each cycle is driven, and the queue is popped and compared one edge later.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_EM, reg_wr_EM;
    logic [4:0]  rd_EM;
    logic [1:0]  wb_sel_EM;
    logic [2:0]  funct3_EM;
    logic [31:0] alu_out_EM, pc_EM, csr_rdata_EM, dmem_rdata;
    logic        valid_MW, reg_wrMW;
    logic [4:0]  waddr_MW;
    logic [31:0] wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
    logic [3:0]  retire_count_w4;
    logic        valid_w4, wr_w4;
    logic [4:0]  waddr_w4;
    logic [31:0] wdata_w4;
`endif

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } mw_t;

    mw_t         exp_q[$];
    mw_t         model;
    logic [31:0] cnt_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_wb_writeback #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_EM(valid_EM), .reg_wr_EM(reg_wr_EM), .rd_EM(rd_EM),
        .wb_sel_EM(wb_sel_EM), .funct3_EM(funct3_EM), .alu_out_EM(alu_out_EM),
        .pc_EM(pc_EM), .csr_rdata_EM(csr_rdata_EM), .dmem_rdata(dmem_rdata),
        .valid_MW(valid_MW), .reg_wrMW(reg_wrMW), .waddr_MW(waddr_MW), .wdata(wdata)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

`ifdef WB_RETIRE_CNT_EN
    // Narrow-counter copy so that wrap-around is reached within a short run.
    mem_wb_writeback #(.XLEN(32), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_EM(valid_EM), .reg_wr_EM(reg_wr_EM), .rd_EM(rd_EM),
        .wb_sel_EM(wb_sel_EM), .funct3_EM(funct3_EM), .alu_out_EM(alu_out_EM),
        .pc_EM(pc_EM), .csr_rdata_EM(csr_rdata_EM), .dmem_rdata(dmem_rdata),
        .valid_MW(valid_w4), .reg_wrMW(wr_w4), .waddr_MW(waddr_w4), .wdata(wdata_w4),
        .retire_count(retire_count_w4)
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_wdata(input logic [1:0] sel, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] pc,
                                              input logic [31:0] csr, input logic [31:0] dm);
        logic [31:0] sh;
        case (sel)
            2'b00: return alu;
            2'b10: return pc + 32'd4;
            2'b11: return csr;
            default: begin
                if (f3[1:0] == 2'b00) begin
                    sh = dm >> (8 * alu[1:0]);
                    return f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                end else if (f3[1:0] == 2'b01) begin
                    sh = dm >> (16 * alu[1]);
                    return f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                end
                return dm;
            end
        endcase
    endfunction

    // Drive one cycle, predict the post-edge state, then compare after the edge.
    task automatic drive(input logic r, input logic st, input logic fl, input logic v,
                         input logic w, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] csr, input logic [31:0] dm);
        mw_t e;
        rst = r; stall = st; flush = fl; valid_EM = v; reg_wr_EM = w; rd_EM = rd;
        wb_sel_EM = sel; funct3_EM = f3; alu_out_EM = alu; pc_EM = pc;
        csr_rdata_EM = csr; dmem_rdata = dm;
        if (r || fl) begin
            model = '0;
        end else if (!st) begin
            model.valid = v;
            model.wr    = v && w && (rd != 5'd0);
            model.addr  = rd;
            model.data  = ref_wdata(sel, f3, alu, pc, csr, dm);
        end
        if (r) cnt_m = 32'd0;
        else if (!fl && !st && v) cnt_m = cnt_m + 32'd1;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("valid_MW", valid_MW, e.valid);
        check("reg_wrMW", reg_wrMW, e.wr);
        check("waddr_MW", waddr_MW, e.addr);
        check("wdata", wdata, e.data);
`ifdef WB_RETIRE_CNT_EN
        check("retire_count", retire_count, cnt_m);
        check("retire_count_w4", retire_count_w4, cnt_m[3:0]);
`endif
    endtask

    localparam logic [31:0] DM = 32'h80F1_7F02;

    initial begin
        model = '0;
        cnt_m = 32'd0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_EM = 1'b0; reg_wr_EM = 1'b0;
        rd_EM = '0; wb_sel_EM = '0; funct3_EM = '0; alu_out_EM = '0; pc_EM = '0;
        csr_rdata_EM = '0; dmem_rdata = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a live writing instruction at the input.
        drive(1, 0, 0, 1, 1, 5'd5, 2'b00, 3'b010, 32'h1234ABCD, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 5'd5, 2'b00, 3'b010, 32'h1234ABCD, 0, 0, 0);
        check("rst_valid", valid_MW, 1'b0);
        check("rst_wr", reg_wrMW, 1'b0);
        check("rst_wdata", wdata, 32'h0);

        // ALU writeback, then the same to x0.
        drive(0, 0, 0, 1, 1, 5'd5, 2'b00, 3'b010, 32'h1234ABCD, 0, 0, 0);
        check("alu_wr", reg_wrMW, 1'b1);
        check("alu_addr", waddr_MW, 5'd5);
        check("alu_data", wdata, 32'h1234ABCD);
        drive(0, 0, 0, 1, 1, 5'd0, 2'b00, 3'b010, 32'h1234ABCD, 0, 0, 0);
        check("x0_wr", reg_wrMW, 1'b0);

        // Load alignment.
        drive(0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b000, 32'h0000_1003, 0, 0, DM);
        check("lb_off3", wdata, 32'hFFFFFF80);
        drive(0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b100, 32'h0000_1003, 0, 0, DM);
        check("lbu_off3", wdata, 32'h00000080);
        drive(0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b001, 32'h0000_1002, 0, 0, DM);
        check("lh_off2", wdata, 32'hFFFF80F1);
        drive(0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b101, 32'h0000_1000, 0, 0, DM);
        check("lhu_off0", wdata, 32'h00007F02);
        drive(0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b010, 32'h0000_1001, 0, 0, DM);
        check("lw_off1", wdata, 32'h80F17F02);
        drive(0, 0, 0, 1, 1, 5'd9, 2'b01, 3'b111, 32'h0000_1003, 0, 0, DM);
        check("f3_111_word", wdata, 32'h80F17F02);

        // PC+4 including wrap, and CSR.
        drive(0, 0, 0, 1, 1, 5'd1, 2'b10, 3'b000, 32'h5, 32'h0000_0100, 0, 0);
        check("pc4", wdata, 32'h00000104);
        drive(0, 0, 0, 1, 1, 5'd1, 2'b10, 3'b000, 32'h5, 32'hFFFF_FFFC, 0, 0);
        check("pc4_wrap", wdata, 32'h00000000);
        drive(0, 0, 0, 1, 1, 5'd2, 2'b11, 3'b000, 32'h5, 0, 32'hDEADBEEF, 0);
        check("csr", wdata, 32'hDEADBEEF);

        // Invalid instruction never writes.
        drive(0, 0, 0, 0, 1, 5'd3, 2'b00, 3'b000, 32'h77, 0, 0, 0);
        check("invalid_wr", reg_wrMW, 1'b0);

        // Stall holds the captured instruction against new inputs.
        drive(0, 0, 0, 1, 1, 5'd7, 2'b00, 3'b000, 32'h11, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 1, 5'(10 + i), 2'b11, 3'b000, 32'h99, 0, 32'hCAFE0000 + i, 0);
            check("stall_addr", waddr_MW, 5'd7);
            check("stall_data", wdata, 32'h11);
            check("stall_wr", reg_wrMW, 1'b1);
        end
        drive(0, 1, 1, 1, 1, 5'd4, 2'b00, 3'b000, 32'h44, 0, 0, 0);
        check("stallflush_valid", valid_MW, 1'b0);
        check("stallflush_wr", reg_wrMW, 1'b0);

        // Reset wins over a simultaneous stall.
        drive(0, 0, 0, 1, 1, 5'd8, 2'b00, 3'b000, 32'h88, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 5'd8, 2'b00, 3'b000, 32'h88, 0, 0, 0);
        check("rst_stall_data", wdata, 32'h0);

        // Ten counted captures mixed with two stalled and one flushed cycle.
        for (int i = 0; i < 13; i++) begin
            drive(0, (i == 3 || i == 7), (i == 10), 1, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i), 0, 0, 0);
        end
`ifdef WB_RETIRE_CNT_EN
        check("retire_ten", retire_count, 32'd10);
`endif

        // Random traffic; the narrow counter wraps several times.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0, 1'($urandom),
                  5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom,
                  $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
